// File: rtl/ren_conv_engine_v2.sv
// ren_conv_engine_v2: multi-channel 1-D convolution with shift, saturation and pair pooling.
// Ports:
//   clk, reset_n (sync, active-low), soft_rst (sync abort), start (rising edge launches)
//   cfg_*            run configuration, sampled at launch
//   img_addr/img_rd  image RAM read port, data on img_data one cycle later
//   kern_addr/kern_rd kernel RAM read port, data on kern_data one cycle later
//   rslt_addr/rslt_we/rslt_data  result RAM write port
//   busy, done (sticky), overflow (sticky saturation flag)
module ren_conv_engine_v2 #(
    parameter int CHANNELS        = 3,
    parameter int PIX_WIDTH       = 8,
    parameter int KERN_COL_WIDTH  = 3,
    parameter int COL_WIDTH       = 8,
    parameter int KERN_CNT_WIDTH  = 3,
    parameter int IMG_ADDR_WIDTH  = 8,
    parameter int KERN_ADDR_WIDTH = 5,
    parameter int RSLT_ADDR_WIDTH = 8,
    parameter int RSLT_WIDTH      = 20
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          soft_rst,
    input  logic [KERN_COL_WIDTH-1:0]     cfg_kern_cols,
    input  logic [COL_WIDTH-1:0]          cfg_cols,
    input  logic [KERN_CNT_WIDTH-1:0]     cfg_kerns,
    input  logic [7:0]                    cfg_stride,
    input  logic                          cfg_kern_addr_mode,
    input  logic [3:0]                    cfg_shift,
    input  logic [1:0]                    cfg_pool_mode,
    input  logic [CHANNELS-1:0]           cfg_mask,
    input  logic [RSLT_ADDR_WIDTH-1:0]    cfg_result_cols,
    output logic [IMG_ADDR_WIDTH-1:0]     img_addr,
    output logic                          img_rd,
    input  logic [CHANNELS*PIX_WIDTH-1:0] img_data,
    output logic [KERN_ADDR_WIDTH-1:0]    kern_addr,
    output logic                          kern_rd,
    input  logic [CHANNELS*PIX_WIDTH-1:0] kern_data,
    output logic [RSLT_ADDR_WIDTH-1:0]    rslt_addr,
    output logic                          rslt_we,
    output logic [RSLT_WIDTH-1:0]         rslt_data,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow
);
    localparam int AW = 2*PIX_WIDTH + $clog2(CHANNELS) + KERN_COL_WIDTH + 1;
    localparam int VW = AW > RSLT_WIDTH ? AW : RSLT_WIDTH + 1;
    localparam int IW = COL_WIDTH + 9;
    localparam int KW = KERN_CNT_WIDTH + KERN_COL_WIDTH + 4;

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, POST, DONE} state_t;
    state_t state, state_nx;

    logic                       rst, start_q, launch, sat, wr, stop;
    logic [KERN_COL_WIDTH-1:0]  kern_cols_q, kc;
    logic [COL_WIDTH-1:0]       cols_q, p;
    logic [KERN_CNT_WIDTH-1:0]  kerns_q, k;
    logic [7:0]                 stride_q;
    logic                       mode_q;
    logic [3:0]                 shift_q;
    logic [1:0]                 pool_q;
    logic [CHANNELS-1:0]        mask_q;
    logic [RSLT_ADDR_WIDTH-1:0] result_cols_q, wptr;
    logic [AW-1:0]              acc, lane_sum;
    logic [VW-1:0]              v_full;
    logic [RSLT_WIDTH-1:0]      v, held, pooled;

    assign rst    = ~reset_n | soft_rst;
    assign launch = state == IDLE && start && !start_q;

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < CHANNELS; l++)
            lane_sum += mask_q[l] ? AW'(img_data[l*PIX_WIDTH +: PIX_WIDTH]) * AW'(kern_data[l*PIX_WIDTH +: PIX_WIDTH]) : '0;
    end

    assign v_full = VW'(acc >> shift_q);
    assign sat    = |v_full[VW-1:RSLT_WIDTH];
    assign v      = sat ? '1 : v_full[RSLT_WIDTH-1:0];
    // even positions in a pooled mode only emit when they are the unpaired last one, so they pass v through
    assign pooled = pool_q == 2'b00 || !p[0] ? v :
                    pool_q == 2'b10 ? RSLT_WIDTH'(({1'b0, held} + {1'b0, v}) >> 1) :
                    held > v ? held : v;
    assign wr     = pool_q == 2'b00 || p[0] || p == cols_q;
    assign stop   = (wr && wptr == result_cols_q) || (p == cols_q && k == kerns_q);

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx  = state;
        img_rd    = 1'b0;
        kern_rd   = 1'b0;
        img_addr  = '0;
        kern_addr = '0;
        rslt_we   = 1'b0;
        rslt_addr = '0;
        rslt_data = '0;
        busy      = 1'b0;
        case (state)
            IDLE:  state_nx = launch ? ACCUM : IDLE;
            ACCUM: begin
                img_rd    = 1'b1;
                kern_rd   = 1'b1;
                img_addr  = IMG_ADDR_WIDTH'(IW'(p) * IW'(stride_q) + IW'(kc));
                kern_addr = KERN_ADDR_WIDTH'((KW'(k) << (mode_q ? 3 : 2)) + KW'(kc));
                busy      = 1'b1;
                state_nx  = kc == kern_cols_q ? DRAIN : ACCUM;
            end
            DRAIN: begin
                busy     = 1'b1;
                state_nx = POST;
            end
            POST:  begin
                busy      = 1'b1;
                rslt_we   = wr;
                rslt_addr = wr ? wptr : '0;
                rslt_data = wr ? pooled : '0;
                state_nx  = stop ? DONE : ACCUM;
            end
            DONE:  state_nx = start ? DONE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q       <= 1'b0;
            kern_cols_q   <= '0;
            cols_q        <= '0;
            kerns_q       <= '0;
            stride_q      <= '0;
            mode_q        <= 1'b0;
            shift_q       <= '0;
            pool_q        <= '0;
            mask_q        <= '0;
            result_cols_q <= '0;
            kc            <= '0;
            p             <= '0;
            k             <= '0;
            wptr          <= '0;
            acc           <= '0;
            held          <= '0;
            done          <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            start_q <= start;
            if (launch) begin
                kern_cols_q   <= cfg_kern_cols;
                cols_q        <= cfg_cols;
                kerns_q       <= cfg_kerns;
                stride_q      <= cfg_stride == 8'd0 ? 8'd1 : cfg_stride;
                mode_q        <= cfg_kern_addr_mode;
                shift_q       <= cfg_shift;
                pool_q        <= cfg_pool_mode;
                mask_q        <= cfg_mask;
                result_cols_q <= cfg_result_cols;
                kc            <= '0;
                p             <= '0;
                k             <= '0;
                wptr          <= '0;
                acc           <= '0;
                done          <= 1'b0;
                overflow      <= 1'b0;
            end
            // read data trails the address by one cycle, so kc=0 has nothing to add yet
            if (state == ACCUM) begin
                acc <= |kc ? acc + lane_sum : acc;
                kc  <= kc + 1'b1;
            end
            if (state == DRAIN) begin
                acc <= acc + lane_sum;
                kc  <= '0;
            end
            if (state == POST) begin
                acc      <= '0;
                overflow <= overflow | sat;
                held     <= p[0] ? held : v;
                wptr     <= wr ? wptr + 1'b1 : wptr;
                p        <= p != cols_q ? p + 1'b1 : '0;
                k        <= p == cols_q && k != kerns_q ? k + 1'b1 : k;
                done     <= stop;
            end
        end
    end
endmodule

// File: tb/tb_ren_conv_engine_v2.sv
// tb_ren_conv_engine_v2: randomized and directed checks of ren_conv_engine_v2 against a behavioural model.
module tb_ren_conv_engine_v2;
    localparam int CH = 3, PW = 8, RW = 20;

    logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0, soft_rst = 1'b0;
    logic [2:0]    cfg_kern_cols = '0;
    logic [7:0]    cfg_cols = '0;
    logic [2:0]    cfg_kerns = '0;
    logic [7:0]    cfg_stride = 8'd1;
    logic          cfg_kern_addr_mode = 1'b0;
    logic [3:0]    cfg_shift = '0;
    logic [1:0]    cfg_pool_mode = '0;
    logic [2:0]    cfg_mask = 3'b111;
    logic [7:0]    cfg_result_cols = 8'd255;
    logic [7:0]    img_addr, rslt_addr;
    logic [4:0]    kern_addr;
    logic          img_rd, kern_rd, rslt_we, busy, done, overflow;
    logic [23:0]   img_data = '0, kern_data = '0;
    logic [RW-1:0] rslt_data;

    ren_conv_engine_v2 dut (
        .clk(clk), .reset_n(reset_n), .start(start), .soft_rst(soft_rst),
        .cfg_kern_cols(cfg_kern_cols), .cfg_cols(cfg_cols), .cfg_kerns(cfg_kerns),
        .cfg_stride(cfg_stride), .cfg_kern_addr_mode(cfg_kern_addr_mode), .cfg_shift(cfg_shift),
        .cfg_pool_mode(cfg_pool_mode), .cfg_mask(cfg_mask), .cfg_result_cols(cfg_result_cols),
        .img_addr(img_addr), .img_rd(img_rd), .img_data(img_data),
        .kern_addr(kern_addr), .kern_rd(kern_rd), .kern_data(kern_data),
        .rslt_addr(rslt_addr), .rslt_we(rslt_we), .rslt_data(rslt_data),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    logic [23:0] img_mem [256];
    logic [23:0] kern_mem [32];
    always @(posedge clk) if (img_rd) img_data <= img_mem[img_addr];
    always @(posedge clk) if (kern_rd) kern_data <= kern_mem[kern_addr];

    int     checks = 0, errors = 0, cyc = 0, last_wr = -1, ea;
    longint ed;
    bit     chk_gap = 0, exp_ov = 0;
    int     exp_addr[$];
    longint exp_data[$];
    longint got_data[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rslt_we) begin
            checks++;
            if (exp_addr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %0d data %0d, no write expected", rslt_addr, rslt_data);
            end else begin
                ea = exp_addr.pop_front();
                ed = exp_data.pop_front();
                if (rslt_addr != ea[7:0] || longint'(rslt_data) != ed) begin
                    errors++;
                    $display("FAIL write: got addr %0d data %0d expected addr %0d data %0d", rslt_addr, rslt_data, ea, ed);
                end
                got_data.push_back(longint'(rslt_data));
            end
            if (chk_gap && last_wr >= 0) chk("write_gap", cyc - last_wr, int'(cfg_kern_cols) + 3);
            last_wr = cyc;
        end
    end

    function automatic longint lane(input logic [23:0] w, input int l);
        return longint'((w >> (l*PW)) & 24'hFF);
    endfunction

    task automatic build_model();
        longint acc, v, held, mx;
        int s, cnt, n, kk;
        exp_addr.delete();
        exp_data.delete();
        exp_ov = 0;
        cnt = 0;
        held = 0;
        mx = (longint'(1) << RW) - 1;
        s = cfg_stride == 0 ? 1 : int'(cfg_stride);
        n = int'(cfg_cols) + 1;
        kk = int'(cfg_kern_cols) + 1;
        for (int k = 0; k <= int'(cfg_kerns); k++)
            for (int p = 0; p < n; p++) begin
                acc = 0;
                for (int c = 0; c < kk; c++)
                    for (int l = 0; l < CH; l++)
                        if (cfg_mask[l])
                            acc += lane(img_mem[(p*s + c) % 256], l) *
                                   lane(kern_mem[(k*(4 << cfg_kern_addr_mode) + c) % 32], l);
                v = acc >> cfg_shift;
                if (v > mx) begin
                    v = mx;
                    exp_ov = 1;
                end
                if (cfg_pool_mode != 0 && p % 2 == 0 && p != n - 1) begin
                    held = v;
                    continue;
                end
                if (cfg_pool_mode != 0 && p % 2 == 1)
                    v = cfg_pool_mode == 2 ? (held + v) >> 1 : (held > v ? held : v);
                exp_addr.push_back(cnt);
                exp_data.push_back(v);
                cnt++;
                if (cnt == int'(cfg_result_cols) + 1) return;
            end
    endtask

    task automatic set_cfg(input int kc, input int cols, input int kerns, input int stride, input int mode,
                           input int shift, input int pool, input int mask, input int rc);
        cfg_kern_cols = 3'(kc);
        cfg_cols = 8'(cols);
        cfg_kerns = 3'(kerns);
        cfg_stride = 8'(stride);
        cfg_kern_addr_mode = 1'(mode);
        cfg_shift = 4'(shift);
        cfg_pool_mode = 2'(pool);
        cfg_mask = 3'(mask);
        cfg_result_cols = 8'(rc);
    endtask

    task automatic run(input string nm);
        int n;
        build_model();
        got_data.delete();
        chk_gap = cfg_pool_mode == 0;
        last_wr = -1;
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        chk({nm, "_busy_at_launch"}, busy, 1);
        n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done"}, done, 1);
        chk({nm, "_missing_writes"}, exp_addr.size(), 0);
        chk({nm, "_overflow"}, overflow, exp_ov);
        repeat (3) @(negedge clk);
        chk({nm, "_no_relaunch"}, busy, 0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk({nm, "_done_held"}, done, 1);
        chk_gap = 0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) img_mem[i] = '0;
        for (int i = 0; i < 32; i++) kern_mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_we", rslt_we, 0);
        chk("reset_rd", img_rd, 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 256; i++) img_mem[i] = 24'h010101;
        for (int i = 0; i < 32; i++) kern_mem[i] = 24'h010101;
        set_cfg(2, 7, 0, 1, 0, 0, 0, 7, 255);
        run("flat");
        chk("flat_count", got_data.size(), 8);
        for (int i = 0; i < got_data.size(); i++) chk($sformatf("flat_val%0d", i), got_data[i], 9);

        for (int i = 0; i < 256; i++) img_mem[i] = {3{8'(i)}};
        set_cfg(1, 7, 0, 1, 0, 0, 1, 7, 255);
        run("max2");
        chk("max2_count", got_data.size(), 4);
        for (int i = 0; i < got_data.size(); i++) chk($sformatf("max2_val%0d", i), got_data[i], 12*i + 9);

        set_cfg(1, 7, 0, 1, 0, 0, 2, 7, 255);
        run("avg2");
        chk("avg2_count", got_data.size(), 4);
        for (int i = 0; i < got_data.size(); i++) chk($sformatf("avg2_val%0d", i), got_data[i], 12*i + 6);

        set_cfg(1, 3, 0, 2, 0, 1, 0, 1, 255);
        run("stride");
        chk("stride_count", got_data.size(), 4);
        for (int i = 0; i < got_data.size(); i++) chk($sformatf("stride_val%0d", i), got_data[i], 2*i);

        for (int i = 0; i < 32; i++) kern_mem[i] = {3{8'(i/4 + 1)}};
        set_cfg(1, 4, 1, 1, 0, 0, 1, 7, 4);
        run("multi");
        chk("multi_count", got_data.size(), 5);
        if (got_data.size() == 5) begin
            chk("multi_val0", got_data[0], 9);
            chk("multi_val1", got_data[1], 21);
            chk("multi_val2", got_data[2], 27);
            chk("multi_val3", got_data[3], 18);
            chk("multi_val4", got_data[4], 42);
        end

        for (int i = 0; i < 256; i++) img_mem[i] = 24'hFFFFFF;
        for (int i = 0; i < 32; i++) kern_mem[i] = 24'hFFFFFF;
        set_cfg(7, 3, 0, 1, 0, 0, 0, 7, 255);
        run("sat");
        chk("sat_count", got_data.size(), 4);
        for (int i = 0; i < got_data.size(); i++) chk($sformatf("sat_val%0d", i), got_data[i], 1048575);
        chk("sat_overflow_lit", overflow, 1);

        build_model();
        got_data.delete();
        @(negedge clk) start = 1'b1;
        n = 0;
        while (got_data.size() < 1 && n < 2000) begin @(negedge clk); n++; end
        chk("abort_first_write", got_data.size(), 1);
        n = 0;
        while (!img_rd && n < 100) begin @(negedge clk); n++; end
        chk("abort_in_accum", img_rd, 1);
        exp_addr.delete();
        exp_data.delete();
        reset_n = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_we", rslt_we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_overflow", overflow, 0);
        @(negedge clk) reset_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("abort_idle_busy", busy, 0);

        for (int i = 0; i < 256; i++) img_mem[i] = 24'h010101;
        for (int i = 0; i < 32; i++) kern_mem[i] = 24'h010101;
        set_cfg(2, 7, 0, 1, 0, 0, 0, 7, 255);
        build_model();
        @(negedge clk) start = 1'b1;
        repeat (7) @(negedge clk);
        exp_addr.delete();
        exp_data.delete();
        soft_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("softrst_busy", busy, 0);
        chk("softrst_we", rslt_we, 0);
        @(negedge clk);
        start = 1'b0;
        soft_rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("softrst_idle", busy, 0);

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 256; i++) img_mem[i] = 24'($urandom);
            for (int i = 0; i < 32; i++) kern_mem[i] = 24'($urandom);
            set_cfg($urandom_range(7), $urandom_range(15), $urandom_range(3), $urandom_range(4),
                    $urandom_range(1), $urandom_range(15), $urandom_range(3), $urandom_range(7),
                    $urandom_range(40));
            run($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ren_conv_engine_v2.md
Name: ren_conv_engine_v2

Overview:
Parametrised successor of the per-instance convolution core inside the Wishbone-mapped accelerator. It runs a multi-channel 1-D convolution of image words against up to 2^KERN_CNT_WIDTH kernels, then applies shift, saturation and optional pooling. Results are written to the result DFFRAM.
The register block above it drives the config fields. It sits between the image, kernel and result DFFRAMs, using their 1-cycle-latency read ports and write port.
New versus the previous core: the channel count is a parameter, stride is real, pooling has four modes (none, max2, avg2, relu+max2), there is a result-count limit, and a sticky overflow flag reports saturation.

Parameters:
CHANNELS, 3, number of pixel lanes packed in one image/kernel word
PIX_WIDTH, 8, unsigned bits per lane
KERN_COL_WIDTH, 3, width of cfg_kern_cols (max 2^KERN_COL_WIDTH kernel columns)
COL_WIDTH, 8, width of cfg_cols
KERN_CNT_WIDTH, 3, width of cfg_kerns
IMG_ADDR_WIDTH, 8, image RAM address width
KERN_ADDR_WIDTH, 5, kernel RAM address width
RSLT_ADDR_WIDTH, 8, result RAM address width
RSLT_WIDTH, 20, result word width

Ports:
clk  in  1  clock; all logic is on the rising edge
reset_n  in  1  synchronous, active-low reset
start  in  1  level from the control register; a rising edge launches a run
soft_rst  in  1  synchronous abort, same effect as reset
cfg_kern_cols  in  KERN_COL_WIDTH  number of kernel columns minus 1 (K = value+1)
cfg_cols  in  COL_WIDTH  number of output positions per kernel minus 1 (N = value+1)
cfg_kerns  in  KERN_CNT_WIDTH  number of kernels minus 1
cfg_stride  in  8  image column step between output positions; 0 is treated as 1
cfg_kern_addr_mode  in  1  kernel base = k*(4<<mode)
cfg_shift  in  4  right shift applied to the accumulator
cfg_pool_mode  in  2  00 none, 01 max2, 10 avg2, 11 relu-then-max2 (identical to max2, because values are unsigned)
cfg_mask  in  CHANNELS  lane enable; a 0 bit zeroes that lane's product
cfg_result_cols  in  RSLT_ADDR_WIDTH  number of results to write minus 1
img_addr  out  IMG_ADDR_WIDTH  image read address
img_rd  out  1  image read strobe; data is valid on the next cycle
img_data  in  CHANNELS*PIX_WIDTH  image word; lane 0 is bits [PIX_WIDTH-1:0]
kern_addr  out  KERN_ADDR_WIDTH  kernel read address
kern_rd  out  1  kernel read strobe; data is valid on the next cycle
kern_data  in  CHANNELS*PIX_WIDTH  kernel word
rslt_addr  out  RSLT_ADDR_WIDTH  result write address
rslt_we  out  1  result write strobe, one cycle per result
rslt_data  out  RSLT_WIDTH  result word
busy  out  1  high from run launch until DONE is entered
done  out  1  sticky completion flag
overflow  out  1  sticky; set if any result saturated during the run

Behaviour:
- Reset (reset_n=0 or soft_rst=1 at a clock edge):
  - all outputs go to 0, the FSM returns to IDLE, accumulators and pointers clear;
  - this takes effect even mid-run, so no rslt_we appears in the following cycle;
  - soft_rst has priority over start.
- FSM states: IDLE, ACCUM, DRAIN, POST, DONE.
- IDLE:
  - a start rising edge (start=1 and start_q=0) enters ACCUM with k=0, p=0, wptr=0;
  - on entry, busy=1, done=0 and overflow=0;
  - the config inputs are sampled at this edge and held for the whole run.
- ACCUM, K cycles, kc = 0..K-1:
  - img_addr = p*stride + kc, truncated modulo 2^IMG_ADDR_WIDTH;
  - kern_addr = k*(4<<mode) + kc, modulo 2^KERN_ADDR_WIDTH;
  - img_rd = kern_rd = 1;
  - accumulation of returned data begins one cycle after the first read;
  - acc += sum over lanes of mask[l] * img_lane * kern_lane, all unsigned;
  - acc width = 2*PIX_WIDTH + clog2(CHANNELS) + KERN_COL_WIDTH + 1, so the accumulator itself never wraps.
- DRAIN, 1 cycle: accumulates the final kc. Read strobes are 0.
- POST, 1 cycle:
  - v = acc >> cfg_shift;
  - if v > 2^RSLT_WIDTH-1, v saturates to all-ones and overflow is set;
  - acc clears.
- POST with pool mode 00: write v.
- POST with pool modes 01, 10, 11:
  - even p: hold v, no write;
  - odd p: write max(held, v) for max modes, or (held+v)>>1 with a RSLT_WIDTH+1-bit sum for avg2;
  - if p = N-1 with N odd, write the held value alone.
- Write rules:
  - rslt_addr = wptr, then wptr increments;
  - a write at wptr = cfg_result_cols goes to DONE right after POST, truncating the remaining work.
- Advance after POST:
  - if p < N-1: p+1, back to ACCUM;
  - else if k < kerns: k+1, p=0, back to ACCUM;
  - else DONE.
- Pooling pairs never span kernels. Each kernel's results are contiguous.
- Throughput: K+2 cycles per output position.
- DONE:
  - busy=0 and done=1, held while start=1;
  - start=0 returns to IDLE, with done held until the next launch or reset;
  - start held high never relaunches.
- A start edge while busy is ignored.

Test Plan:
- Flat sum:
  - stimulus: all image and kernel lanes = 1, K=3, N=8, 1 kernel, mask=111, shift=0, pool=00;
  - required: 8 writes of 9 at addr 0..7, one write every 5 cycles, then done=1, busy=0, overflow=0.
- Max2 pooling:
  - stimulus: img[i] lanes = i, kernel lanes = 1, K=2, N=8, pool=01;
  - required: results 9, 21, 33, 45 at addr 0..3.
- Avg2 pooling:
  - stimulus: same as max2 with pool=10;
  - required: 6, 18, 30, 42.
- Stride, mask and shift:
  - stimulus: img[i] lanes = i, kernel = 1, K=2, stride=2, N=4, mask=001, shift=1;
  - required: (2p + 2p+1)>>1 = 0, 2, 4, 6.
- Multi-kernel and limit:
  - stimulus: 2 kernels, kernel words k+1, mode 0, N=5 with max2, result_cols=4;
  - required: kernel 0 writes addr 0..2, where addr 2 is the unpaired position 4; kernel 1 writes addr 3..4 and then the run stops; done=1.
- Saturation and abort:
  - stimulus 1: all lanes 255, K=8, mask=111;
  - required 1: every result = 1048575 and overflow=1;
  - stimulus 2: rerun and assert reset_n=0 during ACCUM;
  - required 2: rslt_we=0, busy=0, done=0 and overflow=0 on the next cycle, and no writes occur afterwards.
